// File: rtl/conv1d_seq_engine.sv
// Sequenced int8 1D convolution engine behind a CFU command/response port.
// Commands fill the buffers and set parameters; START runs a LANES-wide MAC loop per output position.
module conv1d_seq_engine #(
  parameter int MAX_WIDTH     = 1024,
  parameter int MAX_CHANNELS  = 128,
  parameter int KERNEL_LENGTH = 8,
  parameter int LANES         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int PAD      = KERNEL_LENGTH / 2 - 1;
  localparam int IN_BYTES = MAX_WIDTH * MAX_CHANNELS;
  localparam int K_BYTES  = KERNEL_LENGTH * MAX_CHANNELS;
  localparam int IAW      = $clog2(IN_BYTES);
  localparam int KAW      = $clog2(K_BYTES);
  localparam int XW       = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int TW       = $clog2(KERNEL_LENGTH);
  localparam int GMAX     = MAX_CHANNELS / LANES;
  localparam int GW       = (GMAX > 1) ? $clog2(GMAX) : 1;
  localparam int LSH      = $clog2(LANES);
  localparam logic [TW-1:0] TAP_LAST = TW'(KERNEL_LENGTH - 1);

  localparam logic [6:0] OP_WRITE_INPUT  = 7'd1;
  localparam logic [6:0] OP_WRITE_KERNEL = 7'd2;
  localparam logic [6:0] OP_READ_OUTPUT  = 7'd3;
  localparam logic [6:0] OP_START        = 7'd4;
  localparam logic [6:0] OP_SET_PARAM    = 7'd5;
  localparam logic [6:0] OP_READ_IN_BYTE = 7'd6;
  localparam logic [6:0] OP_READ_K_BYTE  = 7'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic               rspValid_q, rspValid_d;
  logic [31:0]        rspData_q, rspData_d;
  logic [31:0]        inputOffset_q, inputOffset_d;
  logic signed [31:0] bias_q, bias_d;
  logic [31:0]        width_q, width_d;
  logic [31:0]        depth_q, depth_d;
  logic signed [31:0] actMin_q, actMin_d;
  logic signed [31:0] actMax_q, actMax_d;
  logic               clampEn_q, clampEn_d;
  logic [XW-1:0]      outX_q, outX_d, lastX_q, lastX_d;
  logic [TW-1:0]      tap_q, tap_d;
  logic [GW-1:0]      group_q, group_d, lastG_q, lastG_d;
  logic signed [31:0] acc_q, acc_d;

  logic [7:0]  inBuf_q  [IN_BYTES];
  logic [7:0]  kBuf_q   [K_BYTES];
  logic [31:0] outBuf_q [MAX_WIDTH];

  logic [6:0]         opcode;
  logic               cmdFire;
  logic               paramsOk;
  logic               inWe, kWe, outWe;
  logic signed [31:0] inX;
  logic [31:0]        laneProd [LANES];
  logic [31:0]        stepSum;
  logic signed [31:0] accNext, yBias, yOut;
  logic [2:0]         unusedFid;

  assign opcode    = cmd_payload_function_id[9:3];
  assign unusedFid = cmd_payload_function_id[2:0];
  assign cmd_ready = ~rspValid_q & (state_q == IDLE);
  assign cmdFire   = cmd_valid & cmd_ready;
  assign rsp_valid = rspValid_q;
  assign rsp_payload_outputs_0 = rspData_q;

  assign paramsOk = (width_q != 32'd0) && (width_q <= 32'(MAX_WIDTH)) &&
                    (depth_q != 32'd0) && (depth_q <= 32'(MAX_CHANNELS));

  assign inX = $signed(32'(outX_q)) + $signed(32'(tap_q)) - PAD;

  // Lanes outside the padded input window or past the last channel contribute zero.
  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic [31:0]        ch;
    logic               laneOk;
    logic signed [7:0]  xByte, wByte;
    logic signed [32:0] xOff;
    assign ch     = (32'(group_q) << LSH) + 32'(l);
    assign laneOk = (inX >= 0) && (inX < $signed(width_q)) && (ch < depth_q);
    assign xByte  = inBuf_q[IAW'(32'(inX) * depth_q + ch)];
    assign wByte  = kBuf_q[KAW'(32'(tap_q) * depth_q + ch)];
    assign xOff   = 33'(xByte) + 33'($signed(inputOffset_q));
    assign laneProd[l] = laneOk ? 32'(wByte * xOff) : 32'd0;
  end

  always_comb begin
    stepSum = '0;
    for (int l = 0; l < LANES; l++) stepSum = stepSum + laneProd[l];
  end

  always_comb begin
    accNext = acc_q + stepSum;
    yBias   = accNext + bias_q;
    yOut    = yBias;
    if (clampEn_q) begin
      if (yOut < actMin_q) yOut = actMin_q;
      if (yOut > actMax_q) yOut = actMax_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    rspValid_d    = rspValid_q;
    rspData_d     = rspData_q;
    inputOffset_d = inputOffset_q;
    bias_d        = bias_q;
    width_d       = width_q;
    depth_d       = depth_q;
    actMin_d      = actMin_q;
    actMax_d      = actMax_q;
    clampEn_d     = clampEn_q;
    outX_d        = outX_q;
    tap_d         = tap_q;
    group_d       = group_q;
    lastX_d       = lastX_q;
    lastG_d       = lastG_q;
    acc_d         = acc_q;
    inWe          = 1'b0;
    kWe           = 1'b0;
    outWe         = 1'b0;

    if (rspValid_q && rsp_ready) rspValid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmdFire) begin
          rspValid_d = 1'b1;
          rspData_d  = '0;
          case (opcode)
            OP_WRITE_INPUT:  inWe = (cmd_payload_inputs_0 < 32'(IN_BYTES / 4));
            OP_WRITE_KERNEL: kWe  = (cmd_payload_inputs_0 < 32'(K_BYTES / 4));
            OP_READ_OUTPUT: begin
              if (cmd_payload_inputs_0 < 32'(MAX_WIDTH))
                rspData_d = outBuf_q[cmd_payload_inputs_0[XW-1:0]];
            end
            OP_START: begin
              if (paramsOk) begin
                rspValid_d = 1'b0;
                state_d    = RUN;
                outX_d     = '0;
                tap_d      = '0;
                group_d    = '0;
                acc_d      = '0;
                lastX_d    = XW'(width_q - 32'd1);
                lastG_d    = GW'(((depth_q + 32'(LANES - 1)) >> LSH) - 32'd1);
              end else begin
                rspData_d = '1;
              end
            end
            OP_SET_PARAM: begin
              case (cmd_payload_inputs_0)
                32'd0:   inputOffset_d = cmd_payload_inputs_1;
                32'd1:   bias_d        = cmd_payload_inputs_1;
                32'd2:   width_d       = cmd_payload_inputs_1;
                32'd3:   depth_d       = cmd_payload_inputs_1;
                32'd4:   actMin_d      = cmd_payload_inputs_1;
                32'd5:   actMax_d      = cmd_payload_inputs_1;
                32'd6:   clampEn_d     = cmd_payload_inputs_1[0];
                default: ;
              endcase
            end
            OP_READ_IN_BYTE: begin
              if (cmd_payload_inputs_0 < 32'(IN_BYTES))
                rspData_d = 32'($signed(inBuf_q[cmd_payload_inputs_0[IAW-1:0]]));
            end
            OP_READ_K_BYTE: begin
              if (cmd_payload_inputs_0 < 32'(K_BYTES))
                rspData_d = 32'($signed(kBuf_q[cmd_payload_inputs_0[KAW-1:0]]));
            end
            default: ;
          endcase
        end
      end
      // Loop order is out_x, then tap, then channel group; the output is written on the last group of the last tap.
      RUN: begin
        acc_d = accNext;
        if (group_q == lastG_q) begin
          group_d = '0;
          if (tap_q == TAP_LAST) begin
            tap_d = '0;
            acc_d = '0;
            outWe = 1'b1;
            if (outX_q == lastX_q) state_d = DONE;
            else                   outX_d  = outX_q + 1'b1;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end else begin
          group_d = group_q + 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        rspValid_d = 1'b1;
        rspData_d  = width_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rspValid_q    <= 1'b0;
      rspData_q     <= '0;
      inputOffset_q <= '0;
      bias_q        <= '0;
      width_q       <= '0;
      depth_q       <= '0;
      actMin_q      <= 32'sh8000_0000;
      actMax_q      <= 32'sh7FFF_FFFF;
      clampEn_q     <= 1'b0;
      outX_q        <= '0;
      tap_q         <= '0;
      group_q       <= '0;
      lastX_q       <= '0;
      lastG_q       <= '0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      rspValid_q    <= rspValid_d;
      rspData_q     <= rspData_d;
      inputOffset_q <= inputOffset_d;
      bias_q        <= bias_d;
      width_q       <= width_d;
      depth_q       <= depth_d;
      actMin_q      <= actMin_d;
      actMax_q      <= actMax_d;
      clampEn_q     <= clampEn_d;
      outX_q        <= outX_d;
      tap_q         <= tap_d;
      group_q       <= group_d;
      lastX_q       <= lastX_d;
      lastG_q       <= lastG_d;
      acc_q         <= acc_d;
    end
  end

  // Buffers have no reset; contents survive an aborted run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (inWe) begin
        inBuf_q[{cmd_payload_inputs_0[IAW-3:0], 2'd0}] <= cmd_payload_inputs_1[7:0];
        inBuf_q[{cmd_payload_inputs_0[IAW-3:0], 2'd1}] <= cmd_payload_inputs_1[15:8];
        inBuf_q[{cmd_payload_inputs_0[IAW-3:0], 2'd2}] <= cmd_payload_inputs_1[23:16];
        inBuf_q[{cmd_payload_inputs_0[IAW-3:0], 2'd3}] <= cmd_payload_inputs_1[31:24];
      end
      if (kWe) begin
        kBuf_q[{cmd_payload_inputs_0[KAW-3:0], 2'd0}] <= cmd_payload_inputs_1[7:0];
        kBuf_q[{cmd_payload_inputs_0[KAW-3:0], 2'd1}] <= cmd_payload_inputs_1[15:8];
        kBuf_q[{cmd_payload_inputs_0[KAW-3:0], 2'd2}] <= cmd_payload_inputs_1[23:16];
        kBuf_q[{cmd_payload_inputs_0[KAW-3:0], 2'd3}] <= cmd_payload_inputs_1[31:24];
      end
      if (outWe) outBuf_q[outX_q] <= yOut;
    end
  end

endmodule

// File: tb/tb_conv1d_seq_engine.sv
// Self-checking bench for conv1d_seq_engine: directed scenarios plus randomized runs
// compared against a plain-arithmetic convolution model.
module tb_conv1d_seq_engine;

  localparam int K     = 8;
  localparam int PAD   = K / 2 - 1;
  localparam int MAXW  = 1024;
  localparam int MAXC  = 128;
  localparam int LANES = 4;

  localparam logic [6:0] OP_WIN  = 7'd1;
  localparam logic [6:0] OP_WK   = 7'd2;
  localparam logic [6:0] OP_ROUT = 7'd3;
  localparam logic [6:0] OP_START = 7'd4;
  localparam logic [6:0] OP_SETP = 7'd5;
  localparam logic [6:0] OP_RIB  = 7'd6;
  localparam logic [6:0] OP_RKB  = 7'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  conv1d_seq_engine dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  byte         mIn  [MAXW*MAXC];
  byte         mK   [K*MAXC];
  int          mOut [MAXW];
  bit          mOutKnown [MAXW];
  int          pOff, pBias, pMin, pMax;
  int unsigned pWidth, pDepth;
  bit          pClamp;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic resetModelParams();
    pOff = 0; pBias = 0; pWidth = 0; pDepth = 0;
    pMin = 32'h8000_0000; pMax = 32'h7FFF_FFFF; pClamp = 1'b0;
  endtask

  // Issues one command and takes its response; holdCycles keeps rsp_ready low while checking the response holds.
  task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int holdCycles, input logic [31:0] holdExp,
                               output logic [31:0] data, output int lat);
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {op, 3'($urandom)};
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 32'(rsp_valid), 32'd1);
    data = rsp_payload_outputs_0;
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_data", rsp_payload_outputs_0, holdExp);
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic writeWord(input logic [6:0] op, input int unsigned addr, input logic [31:0] val);
    logic [31:0] d;
    int lat;
    applyStimulus(op, addr, val, 0, 0, d, lat);
    checkOutput("write_rsp", d, 32'd0);
    for (int b = 0; b < 4; b++) begin
      if (op == OP_WIN && addr < MAXW*MAXC/4) mIn[4*addr+b] = byte'(val[8*b +: 8]);
      if (op == OP_WK  && addr < K*MAXC/4)    mK[4*addr+b]  = byte'(val[8*b +: 8]);
    end
  endtask

  task automatic setParam(input int unsigned id, input logic [31:0] val);
    logic [31:0] d;
    int lat;
    applyStimulus(OP_SETP, id, val, 0, 0, d, lat);
    checkOutput("setp_rsp", d, 32'd0);
    checkOutput("setp_lat", lat, 32'd1);
    case (id)
      0: pOff = val;
      1: pBias = val;
      2: pWidth = val;
      3: pDepth = val;
      4: pMin = val;
      5: pMax = val;
      6: pClamp = val[0];
      default: ;
    endcase
  endtask

  task automatic readCmd(input logic [6:0] op, input logic [31:0] addr, output logic [31:0] d);
    int lat;
    applyStimulus(op, addr, $urandom, 0, 0, d, lat);
  endtask

  function automatic int refOut(int ox);
    longint acc = 0;
    int y;
    for (int t = 0; t < K; t++) begin
      int ix = ox - PAD + t;
      if (ix >= 0 && ix < int'(pWidth))
        for (int c = 0; c < int'(pDepth); c++)
          acc += longint'(mK[t*pDepth+c]) * (longint'(mIn[ix*pDepth+c]) + longint'(pOff));
    end
    y = int'(acc) + pBias;
    if (pClamp) begin
      if (y < pMin) y = pMin;
      if (y > pMax) y = pMax;
    end
    return y;
  endfunction

  task automatic runStart(input string tag, input int holdCycles);
    logic [31:0] d;
    int lat;
    bit ok;
    int g;
    ok = (pWidth > 0) && (pWidth <= MAXW) && (pDepth > 0) && (pDepth <= MAXC);
    applyStimulus(OP_START, $urandom, $urandom, holdCycles, pWidth, d, lat);
    if (ok) begin
      g = (pDepth + LANES - 1) / LANES;
      checkOutput({tag, "_rsp"}, d, pWidth);
      checkOutput({tag, "_lat"}, lat, pWidth*K*g + 2);
      for (int ox = 0; ox < int'(pWidth); ox++) begin
        mOut[ox] = refOut(ox);
        mOutKnown[ox] = 1'b1;
        readCmd(OP_ROUT, ox, d);
        checkOutput({tag, "_out"}, d, mOut[ox]);
      end
      if (pWidth < MAXW && mOutKnown[pWidth]) begin
        readCmd(OP_ROUT, pWidth, d);
        checkOutput({tag, "_untouched"}, d, mOut[pWidth]);
      end
    end else begin
      checkOutput({tag, "_invalid_rsp"}, d, 32'hFFFF_FFFF);
      checkOutput({tag, "_invalid_lat"}, lat, 32'd1);
    end
  endtask

  task automatic fillWords(input logic [6:0] op, input int nBytes, input logic [31:0] val);
    for (int w = 0; w < (nBytes + 3) / 4; w++) writeWord(op, w, val);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat;
    bit seen;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    rsp_ready = 1'b0;
    resetModelParams();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", rsp_payload_outputs_0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    runStart("reset_params", 0);

    $display("[TB] identity kernel");
    setParam(3, 1);
    setParam(2, 4);
    writeWord(OP_WIN, 0, 32'h0403_0201);
    writeWord(OP_WK, 0, 32'h0100_0000);
    writeWord(OP_WK, 1, 32'h0000_0000);
    applyStimulus(OP_START, 0, 0, 0, 0, d, lat);
    checkOutput("t1_rsp", d, 32'd4);
    checkOutput("t1_lat", lat, 32'd34);
    for (int i = 0; i < 4; i++) begin
      readCmd(OP_ROUT, i, d);
      checkOutput("t1_out", d, 32'(i + 1));
    end
    runStart("t1_model", 0);

    $display("[TB] offset and bias");
    setParam(3, 4);
    setParam(2, 1);
    setParam(0, 128);
    setParam(1, 5);
    writeWord(OP_WIN, 0, 32'h8080_8080);
    fillWords(OP_WK, K*4, 32'h0101_0101);
    runStart("t2", 0);
    readCmd(OP_ROUT, 0, d);
    checkOutput("t2_out0", d, 32'd5);
    writeWord(OP_WIN, 0, 32'h0403_0201);
    for (int i = 0; i < 4; i++) begin
      readCmd(OP_RIB, i, d);
      checkOutput("t2_byte", d, 32'(i + 1));
    end
    writeWord(OP_WIN, 1, 32'h7F80_FF00);
    readCmd(OP_RIB, 5, d);
    checkOutput("t2_sext_ff", d, 32'hFFFF_FFFF);
    readCmd(OP_RIB, 6, d);
    checkOutput("t2_sext_80", d, 32'hFFFF_FF80);

    $display("[TB] partial lane group and clamp");
    setParam(0, 0);
    setParam(1, 0);
    setParam(3, 6);
    setParam(2, 8);
    fillWords(OP_WIN, 48, 32'h0101_0101);
    fillWords(OP_WK, K*6, 32'h0202_0202);
    runStart("t3", 0);
    readCmd(OP_ROUT, 0, d); checkOutput("t3_out0", d, 32'd60);
    readCmd(OP_ROUT, 3, d); checkOutput("t3_out3", d, 32'd96);
    readCmd(OP_ROUT, 7, d); checkOutput("t3_out7", d, 32'd48);
    readCmd(OP_RKB, 5, d);  checkOutput("t3_kbyte", d, 32'd2);
    setParam(4, -10);
    setParam(5, 50);
    setParam(6, 1);
    runStart("t4", 0);
    readCmd(OP_ROUT, 0, d); checkOutput("t4_out0", d, 32'd50);
    readCmd(OP_ROUT, 3, d); checkOutput("t4_out3", d, 32'd50);
    readCmd(OP_ROUT, 7, d); checkOutput("t4_out7", d, 32'd48);
    setParam(1, -200);
    runStart("t4_bias_backpressure", 3);
    for (int i = 0; i < 8; i++) begin
      readCmd(OP_ROUT, i, d);
      checkOutput("t4_neg", d, 32'hFFFF_FFF6);
    end

    $display("[TB] reset during run");
    setParam(1, 0);
    setParam(6, 0);
    fillWords(OP_WK, K*6, 32'h0303_0303);
    mOut[0] = refOut(0);
    checkOutput("t5_model_out0", mOut[0], 32'd90);
    @(negedge clk);
    checkOutput("t5_start_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {OP_START, 3'd0};
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("t5_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_ready_after_reset", 32'(cmd_ready), 32'd1);
    checkOutput("t5_no_rsp", 32'(rsp_valid), 32'd0);
    seen = 1'b0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("t5_no_late_rsp", 32'(seen), 32'd0);
    resetModelParams();
    for (int i = 1; i < 7; i++) mOutKnown[i] = 1'b0;
    readCmd(OP_ROUT, 0, d); checkOutput("t5_out0_kept", d, mOut[0]);
    readCmd(OP_ROUT, 7, d); checkOutput("t5_out7_old", d, mOut[7]);
    readCmd(OP_RIB, 10, d); checkOutput("t5_in_kept", d, 32'(int'(mIn[10])));
    readCmd(OP_RKB, 3, d);  checkOutput("t5_k_kept", d, 32'(int'(mK[3])));

    $display("[TB] invalid parameters and addresses");
    setParam(2, 4);
    runStart("t6_depth0", 0);
    setParam(3, 1);
    setParam(2, 1025);
    runStart("t6_width1025", 0);
    setParam(2, 4);
    setParam(3, 129);
    runStart("t6_depth129", 0);
    readCmd(OP_ROUT, 1024, d);  checkOutput("t6_rout_oob", d, 32'd0);
    readCmd(7'd9, 0, d);        checkOutput("t6_bad_op", d, 32'd0);
    writeWord(OP_WIN, MAXW*MAXC/4, 32'h5555_5555);
    readCmd(OP_RIB, MAXW*MAXC, d); checkOutput("t6_rib_oob", d, 32'd0);
    readCmd(OP_RKB, K*MAXC, d);    checkOutput("t6_rkb_oob", d, 32'd0);
    writeWord(OP_WK, K*MAXC/4, 32'h5555_5555);
    readCmd(OP_RKB, 0, d);         checkOutput("t6_k_unchanged", d, 32'(int'(mK[0])));

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      int unsigned w, dp;
      int a, b;
      w  = $urandom_range(1, 12);
      dp = $urandom_range(1, 10);
      setParam(2, w);
      setParam(3, dp);
      setParam(0, (r % 2 == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom);
      setParam(1, $urandom);
      a = $urandom;
      b = $urandom;
      setParam(4, (a < b) ? a : b);
      setParam(5, (a < b) ? b : a);
      setParam(6, $urandom_range(0, 1));
      for (int i = 0; i < (int'(w*dp) + 3) / 4; i++) writeWord(OP_WIN, i, $urandom);
      for (int i = 0; i < (K*int'(dp) + 3) / 4; i++) writeWord(OP_WK, i, $urandom);
      runStart("rand", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
